// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares one fixed-latency memory read port among NREQ requesters.
//   Each cycle one requester is chosen by round-robin priority. A requester
//   that has waited MAXWAIT cycles is promoted ahead of the rest. The
//   winner's address goes to the memory. A {valid, index} tag pipeline
//   steers the returned word back to that requester LAT cycles later.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   req        in   [NREQ]     per-requester level request
//   addr       in   [NREQ*AW]  requester i address at [i*AW +: AW]
//   hold       in   suppresses all grants this cycle
//   gnt        out  [NREQ]     one-hot/zero combinational grant
//   mem_raddr  out  [AW]       memory read address
//   mem_rdata  in   [DW]       memory read data
//   rvalid     out  [NREQ]     one-hot/zero: rdata belongs to requester i
//   rdata      out  [DW]       pass-through of mem_rdata
//   busy       out  any read in flight
module mem_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int LAT     = 2,
  parameter int MAXWAIT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic               hold,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      mem_raddr,
  input  logic [DW-1:0]      mem_rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               busy
);

  localparam int         IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MAXW = 8'(MAXWAIT);

  logic [IW-1:0]           ptr_q, ptr_d;
  logic [7:0]              wcnt_q [NREQ];
  logic [7:0]              wcnt_d [NREQ];
  logic [AW-1:0]           raddr_q;
  logic [LAT-1:0]          tag_vld_q;
  logic [LAT-1:0][IW-1:0]  tag_idx_q;

  logic [NREQ-1:0]         elig, urg;
  logic                    any_urg, any_elig;
  logic [IW-1:0]           w_urg, w_elig, win;

  // Requester index k positions after p, wrapping circularly.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    elig = req & {NREQ{~hold & ~rst}};
    urg  = '0;
    for (int i = 0; i < NREQ; i++) begin
      urg[i] = elig[i] && (wcnt_q[i] >= MAXW);
    end
  end

  // Two circular scans from ptr: the first urgent and the first eligible
  // requester. An urgent winner always takes precedence.
  always_comb begin
    any_urg  = 1'b0;
    any_elig = 1'b0;
    w_urg    = '0;
    w_elig   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (urg[rr_idx(ptr_q, k)] && !any_urg) begin
        any_urg = 1'b1;
        w_urg   = rr_idx(ptr_q, k);
      end
      if (elig[rr_idx(ptr_q, k)] && !any_elig) begin
        any_elig = 1'b1;
        w_elig   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    win       = any_urg ? w_urg : w_elig;
    gnt       = any_elig ? (NREQ'(1) << win) : '0;
    // Address is held when idle; the memory's result for that slot has no tag.
    mem_raddr = any_elig ? addr[win*AW +: AW] : raddr_q;
    ptr_d     = ptr_q;
    if (any_elig) begin
      ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      // Clear wins over increment; hold cycles still count as waiting.
      if (!req[i] || gnt[i]) begin
        wcnt_d[i] = '0;
      end else if (wcnt_q[i] >= MAXW) begin
        wcnt_d[i] = MAXW;
      end else begin
        wcnt_d[i] = wcnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      raddr_q   <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < NREQ; i++) wcnt_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      raddr_q      <= mem_raddr;
      tag_vld_q[0] <= any_elig;
      for (int s = 1; s < LAT; s++) tag_vld_q[s] <= tag_vld_q[s-1];
      for (int i = 0; i < NREQ; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end

  // Tag indices are qualified by tag_vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= win;
    for (int s = 1; s < LAT; s++) tag_idx_q[s] <= tag_idx_q[s-1];
  end

  assign rvalid = tag_vld_q[LAT-1] ? (NREQ'(1) << tag_idx_q[LAT-1]) : '0;
  assign rdata  = mem_rdata;
  assign busy   = |tag_vld_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int LAT     = 2;
  localparam int MAXWAIT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic               hold;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      mem_raddr;
  logic [DW-1:0]      mem_rdata;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT), .MAXWAIT(MAXWAIT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .hold(hold), .gnt(gnt),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .rvalid(rvalid),
    .rdata(rdata), .busy(busy)
  );

  // Memory contents: a fixed function of the word address.
  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {a, 1'b0} ^ 16'hC3A5;
  endfunction

  // LAT-cycle read-latency memory.
  logic [DW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= memfn(mem_raddr);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mem_rdata = mpipe[LAT-1];

  // Reference model state.
  typedef struct {
    int            due;
    int            idx;
    logic [AW-1:0] a;
  } rd_t;
  rd_t           pend[$];
  int            m_ptr;
  int            m_wcnt [NREQ];
  logic [AW-1:0] m_raddr;
  bit            m_known = 1'b0;
  int            cyc_n = 0;
  logic [AW-1:0] a_drv [NREQ];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  // Winner per the arbitration rules: earliest urgent requester from ptr,
  // otherwise earliest requesting one; -1 when none.
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ] && m_wcnt[(m_ptr + k) % NREQ] >= MAXWAIT)
        return (m_ptr + k) % NREQ;
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  // want >= 0 additionally pins gnt to a directed value.
  task automatic cyc(input logic [NREQ-1:0] r, input logic h, input logic rs, input int want);
    int              w;
    logic [NREQ-1:0] eg, erv;
    logic [AW-1:0]   era;
    req  = r;
    hold = h;
    rst  = rs;
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = a_drv[i];
    @(negedge clk);
    w  = (rs || h) ? -1 : pick(r);
    eg = (w >= 0) ? (NREQ'(1) << w) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    if (want >= 0) check("gnt_directed", 32'(gnt), want);
    if (m_known) begin
      era = (w >= 0) ? a_drv[w] : m_raddr;
      check("mem_raddr", 32'(mem_raddr), 32'(era));
      erv = '0;
      if (pend.size() > 0 && pend[0].due == cyc_n) erv = NREQ'(1) << pend[0].idx;
      check("rvalid", 32'(rvalid), 32'(erv));
      check("busy", 32'(busy), 32'(pend.size() > 0));
      if (erv != 0) check("rdata", 32'(rdata), 32'(memfn(pend[0].a)));
    end
    if (pend.size() > 0 && pend[0].due == cyc_n) void'(pend.pop_front());
    if (rs) begin
      m_ptr   = 0;
      m_raddr = '0;
      m_known = 1'b1;
      pend.delete();
      for (int i = 0; i < NREQ; i++) m_wcnt[i] = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!r[i] || i == w) m_wcnt[i] = 0;
        else if (m_wcnt[i] < MAXWAIT) m_wcnt[i]++;
      end
      if (w >= 0) begin
        m_ptr   = (w + 1) % NREQ;
        m_raddr = a_drv[w];
        pend.push_back('{cyc_n + LAT, w, a_drv[w]});
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < NREQ; i++) a_drv[i] = AW'($urandom);
  endtask

  initial begin
    rand_addrs();
    // Reset, then a single requester for three cycles.
    cyc(4'b0000, 1'b0, 1'b1, 0);
    cyc(4'b0000, 1'b0, 1'b1, 0);
    cyc(4'b0000, 1'b0, 1'b0, 0);
    a_drv[0] = 15'h0010;
    repeat (3) cyc(4'b0001, 1'b0, 1'b0, 4'b0001);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0, 0);

    // Round-robin fairness from ptr=0.
    cyc(4'b0000, 1'b0, 1'b1, 0);
    for (int n = 0; n < 8; n++) begin
      rand_addrs();
      cyc(4'b1111, 1'b0, 1'b0, 1 << (n % 4));
    end

    // Hold with two requesters; in-flight reads still return.
    cyc(4'b0011, 1'b0, 1'b0, -1);
    repeat (4) cyc(4'b0011, 1'b1, 1'b0, 0);
    repeat (3) cyc(4'b0011, 1'b0, 1'b0, -1);
    repeat (2) cyc(4'b0000, 1'b0, 1'b0, 0);

    // Starvation: requester 2 waits through a hold, then wins despite ptr=3.
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100);
    repeat (3) cyc(4'b0100, 1'b1, 1'b0, 0);
    cyc(4'b1111, 1'b0, 1'b0, 4'b0100);
    cyc(4'b1111, 1'b0, 1'b0, 4'b1000);
    repeat (2) cyc(4'b0000, 1'b0, 1'b0, 0);

    // Reset while two reads are in flight.
    cyc(4'b0000, 1'b0, 1'b1, 0);
    cyc(4'b0001, 1'b0, 1'b0, 4'b0001);
    cyc(4'b0010, 1'b0, 1'b0, 4'b0010);
    cyc(4'b0011, 1'b0, 1'b1, 0);
    cyc(4'b0011, 1'b0, 1'b0, 4'b0001);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0, 0);

    // Withdrawal and pointer wrap.
    cyc(4'b0000, 1'b0, 1'b1, 0);
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100);
    cyc(4'b1000, 1'b0, 1'b0, 4'b1000);
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0, 0);

    // Randomized traffic with occasional hold and reset.
    for (int n = 0; n < 400; n++) begin
      rand_addrs();
      cyc(NREQ'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), -1);
    end
    repeat (3) cyc(4'b0000, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
